hist_bin_ctrl: RTL
==================

# hist_bin_ctrl

Read-modify-write controller that owns one dual-port bin RAM (1-cycle registered read, port A read/write, port B read-only) and turns it into a HOG cell histogram accumulator. It accepts a stream of (bin, magnitude) votes at one per cycle, forwards around the RAM write/read hazard, and on a flush request streams out all bins in order with a valid/ready handshake. Each bin is cleared as it is read out. It sits between the gradient/orientation stage and the block-normalisation stage, with one RAM instance per cell.

## Interface
- DATA_W, 12, bin accumulator width; equals RAM data width
- ADDR_W, 5, bin index width; NBINS = 2^ADDR_W
- MAG_W, 8, vote magnitude width; MAG_W <= DATA_W
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- i_valid  in  1  vote present
- i_bin  in  ADDR_W  vote bin index
- i_mag  in  MAG_W  vote magnitude, unsigned
- o_ready  out  1  vote accepted when i_valid && o_ready
- i_flush  in  1  single-cycle pulse; request readout
- o_valid  out  1  readout word valid
- o_bin  out  ADDR_W  index of readout word
- o_data  out  DATA_W  bin value
- o_last  out  1  marks bin NBINS-1
- i_ready  in  1  readout word consumed when o_valid && i_ready
- ram_addr_a  out  ADDR_W  RAM port A address (write only)
- ram_we  out  1  RAM port A write enable
- ram_wdata  out  DATA_W  RAM port A write data
- ram_addr_b  out  ADDR_W  RAM port B read address
- ram_rdata_b  in  DATA_W  RAM port B data; ram[addr_b] one cycle after the address is presented

## Operation
- States: CLEAR, ACCUM, DRAIN, RD_ISSUE, RD_CAP, RD_WAIT.
- CLEAR (entered on rst):
  - clr_idx counts 0..NBINS-1; ram_we=1, ram_addr_a=clr_idx, ram_wdata=0, o_ready=0.
  - Goes to ACCUM after writing index NBINS-1.
- ACCUM:
  - o_ready=1.
  - S0: an accepted vote drives ram_addr_b=i_bin and loads s1_bin/s1_mag with s1_vld=1.
  - S1, next cycle: base = (last_vld && last_bin==s1_bin) ? last_wdata : ram_rdata_b; sum = base + s1_mag (width rule under Configuration).
  - S1 write: ram_we=1, ram_addr_a=s1_bin, ram_wdata=sum; last_bin/last_wdata/last_vld are updated from it.
  - A one-deep forward register is sufficient: a write made two cycles earlier is already visible to the port B read.
  - i_flush=1 goes to DRAIN; a vote accepted in the same cycle is still accumulated.
- DRAIN: o_ready=0; the final S1 write completes; rd_idx=0; goes to RD_ISSUE.
- RD_ISSUE: ram_addr_b=rd_idx; goes to RD_CAP.
- RD_CAP:
  - o_data<=ram_rdata_b, o_bin<=rd_idx, o_last<=(rd_idx==NBINS-1), o_valid<=1.
  - ram_we=1, ram_addr_a=rd_idx, ram_wdata=0 (clear-on-read).
  - Goes to RD_WAIT.
- RD_WAIT:
  - Holds o_valid/o_data/o_bin/o_last stable until i_ready.
  - On handshake: o_valid<=0; if o_last, goes to ACCUM (last_vld cleared), else rd_idx++ and goes to RD_ISSUE.
- ram_we is 0 whenever no write is listed above.
- i_flush outside ACCUM is ignored.
- i_valid while o_ready=0 is ignored.

## Timing
- Reset values: state=CLEAR, clr_idx=0, rd_idx=0, s1_vld=0, last_vld=0, o_valid=0, o_bin=0, o_data=0, o_last=0.
- RAM-side outputs are combinational from state registers. In the first cycle after rst: ram_we=1, ram_addr_a=0, ram_wdata=0, ram_addr_b=0.
- o_ready is 0 for exactly NBINS cycles after rst deasserts.
- Vote throughput is 1 per cycle; vote-to-RAM-write latency is 1 cycle.
- Flush at cycle t: first o_valid at t+4. Minimum 3 cycles per bin (RD_ISSUE, RD_CAP, RD_WAIT with i_ready=1).
- A full readout, flush to return to ACCUM, takes 1 + 3*NBINS cycles with i_ready held high.
- rst mid-operation: the next cycle is in CLEAR with all outputs at reset values; in-flight votes and readout are discarded; the RAM is re-zeroed.

## Configuration
- HIST_SAT_EN defined: sum clamps to 2^DATA_W-1 when base + s1_mag overflows DATA_W bits.
- HIST_SAT_EN undefined: sum wraps modulo 2^DATA_W.

## Test plan
- Reset, then flush once o_ready rises -> o_ready low exactly 32 cycles; readout gives 32 words, o_bin 0..31, all o_data=0, o_last only on bin 31.
- Four back-to-back votes bin 3 mag 10, then flush -> bin 3 reads 40, all other bins 0 (forward path exercised).
- Votes bin 1,2,1,2 each mag 5 back-to-back, then vote bin 1 mag 7 two cycles later -> bin 1=17, bin 2=10.
- Twenty votes bin 7 mag 255 (DATA_W=12) -> bin 7=4095 with HIST_SAT_EN; bin 7=1004 without.
- i_ready held low 5 cycles while bin 4 is presented -> o_valid/o_bin/o_data stable throughout; a second flush afterwards reads all zeros.
- rst asserted while bin 10 is in RD_WAIT -> o_valid=0 next cycle, o_ready low 32 cycles; the subsequent flush reads all zeros.

Source files
------------

// File: rtl/hist_bin_ctrl.sv
// hist_bin_ctrl: HOG cell histogram read-modify-write controller over a dual-port bin RAM.
// Define HIST_SAT_EN for saturating accumulation; the default build wraps modulo 2^DATA_W.
module hist_bin_ctrl #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 5,
   parameter int MAG_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_bin,
   input  logic [MAG_W-1:0]  i_mag,
   output logic              o_ready,
   input  logic              i_flush,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_bin,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   input  logic              i_ready,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [ADDR_W-1:0] ram_addr_b,
   input  logic [DATA_W-1:0] ram_rdata_b
);
   typedef enum logic [2:0] {CLEAR, ACCUM, DRAIN, RD_ISSUE, RD_CAP, RD_WAIT} state_t;
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] clr_idx, rd_idx, s1_bin, last_bin;
   logic [MAG_W-1:0] s1_mag;
   logic [DATA_W-1:0] last_wdata, base, sum;
   logic s1_vld, last_vld, accept, hs;
   assign accept = i_valid && o_ready;
   assign hs = o_valid && i_ready;
   // the previous cycle's write has not reached the registered read yet, so forward it
   assign base = (last_vld && last_bin == s1_bin) ? last_wdata : ram_rdata_b;
`ifdef HIST_SAT_EN
   logic [DATA_W:0] sum_ext;
   assign sum_ext = {1'b0, base} + (DATA_W+1)'(s1_mag);
   assign sum = sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
`else
   assign sum = base + DATA_W'(s1_mag);
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         clr_idx <= '0;
         rd_idx <= '0;
         s1_vld <= 1'b0;
         last_vld <= 1'b0;
         o_valid <= 1'b0;
         o_bin <= '0;
         o_data <= '0;
         o_last <= 1'b0;
      end else begin
         state <= state_nxt;
         clr_idx <= (state == CLEAR) ? clr_idx + 1'b1 : '0;
         s1_vld <= accept;
         if (accept) begin
            s1_bin <= i_bin;
            s1_mag <= i_mag;
         end
         last_vld <= s1_vld;
         if (s1_vld) begin
            last_bin <= s1_bin;
            last_wdata <= sum;
         end
         if (state == DRAIN) rd_idx <= '0;
         else if (state == RD_WAIT && hs && !o_last) rd_idx <= rd_idx + 1'b1;
         if (state == RD_CAP) begin
            o_data <= ram_rdata_b;
            o_bin <= rd_idx;
            o_last <= rd_idx == LAST_IDX;
            o_valid <= 1'b1;
         end else if (state == RD_WAIT && hs) o_valid <= 1'b0;
      end
   end
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:    state_nxt = (clr_idx == LAST_IDX) ? ACCUM : CLEAR;
         ACCUM:    state_nxt = i_flush ? DRAIN : ACCUM;
         DRAIN:    state_nxt = RD_ISSUE;
         RD_ISSUE: state_nxt = RD_CAP;
         RD_CAP:   state_nxt = RD_WAIT;
         RD_WAIT:  state_nxt = hs ? (o_last ? ACCUM : RD_ISSUE) : RD_WAIT;
         default:  state_nxt = CLEAR;
      endcase
   end
   always_comb begin
      o_ready = state == ACCUM;
      ram_we = state == CLEAR || state == RD_CAP || s1_vld;
      ram_addr_a = (state == CLEAR) ? clr_idx : (state == RD_CAP) ? rd_idx : s1_bin;
      ram_wdata = (state == CLEAR || state == RD_CAP) ? '0 : sum;
      ram_addr_b = (state == RD_ISSUE) ? rd_idx : (state == ACCUM) ? i_bin : '0;
   end
endmodule
